// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART command decoder: opcodes, operand addresses, FSM states.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StOpA,
    StOpB,
    StFun,
    StAluWait,
    StSendLo,
    StSendHi,
    StSendRd
  } state_e;

endpackage

// File: rtl/sys_ctrl_cmd_if.sv
// Bundle of RX, register-file, ALU and TX-FIFO signals around the command decoder.
interface sys_ctrl_cmd_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUN_W  = 4
);
  logic [DATA_W-1:0]   RX_P_DATA;
  logic                RX_D_VLD;
  logic                RX_ERR;
  logic [DATA_W-1:0]   RF_RdData;
  logic                RF_RdData_VLD;
  logic [2*DATA_W-1:0] ALU_OUT;
  logic                ALU_OUT_VLD;
  logic                FIFO_FULL;
  logic                RF_WrEn;
  logic                RF_RdEn;
  logic [ADDR_W-1:0]   RF_Address;
  logic [DATA_W-1:0]   RF_WrData;
  logic                ALU_EN;
  logic [FUN_W-1:0]    ALU_FUN;
  logic                CLK_GATE_EN;
  logic [DATA_W-1:0]   TX_P_DATA;
  logic                TX_D_VLD;
  logic                BUSY;

  // master is the decoder side
  modport master (
    input  RX_P_DATA, RX_D_VLD, RX_ERR, RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD,
           FIFO_FULL,
    output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD, BUSY
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RX_ERR, RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD,
           FIFO_FULL,
    input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD, BUSY
  );
endinterface

// File: rtl/sys_ctrl_cmd.sv
// UART command decoder: parses WR/RD/ALU frames, strobes the register file and ALU,
// and returns results as bytes into the TX FIFO. All strobes are registered.
module sys_ctrl_cmd
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUN_W  = 4
) (
  input logic            CLK,
  input logic            RST,
  sys_ctrl_cmd_if.master bus
);

  state_e              state_q, state_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                alu_en_q, alu_en_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [FUN_W-1:0]    fun_q, fun_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_vld_q, tx_vld_d;
  logic [DATA_W-1:0]   result_hi_q, result_hi_d;
  logic                rx_ok, rx_bad;

  assign rx_ok  = bus.RX_D_VLD & ~bus.RX_ERR;
  assign rx_bad = bus.RX_D_VLD & bus.RX_ERR;

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    alu_en_d    = 1'b0;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    fun_d       = fun_q;
    tx_data_d   = tx_data_q;
    tx_vld_d    = tx_vld_q;
    result_hi_d = result_hi_q;

    unique case (state_q)
      StIdle: begin
        if (rx_ok) begin
          case (bus.RX_P_DATA)
            CMD_WR:      state_d = StWrAddr;
            CMD_RD:      state_d = StRdAddr;
            CMD_ALU_OP:  state_d = StOpA;
            CMD_ALU_NOP: state_d = StFun;
            default:     state_d = StIdle;
          endcase
        end
      end
      StWrAddr: begin
        if (rx_bad) begin
          state_d = StIdle;
        end else if (rx_ok) begin
          address_d = bus.RX_P_DATA[ADDR_W-1:0];
          state_d   = StWrData;
        end
      end
      StWrData: begin
        if (rx_bad) begin
          state_d = StIdle;
        end else if (rx_ok) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.RX_P_DATA;
          state_d   = StIdle;
        end
      end
      StRdAddr: begin
        if (rx_bad) begin
          state_d = StIdle;
        end else if (rx_ok) begin
          rd_en_d   = 1'b1;
          address_d = bus.RX_P_DATA[ADDR_W-1:0];
          state_d   = StRdWait;
        end
      end
      StRdWait: begin
        if (bus.RF_RdData_VLD) begin
          tx_data_d = bus.RF_RdData;
          tx_vld_d  = 1'b1;
          state_d   = StSendRd;
        end
      end
      StOpA, StOpB: begin
        if (rx_bad) begin
          state_d = StIdle;
        end else if (rx_ok) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.RX_P_DATA;
          address_d = (state_q == StOpA) ? ADDR_W'(OPA_ADDR) : ADDR_W'(OPB_ADDR);
          state_d   = (state_q == StOpA) ? StOpB : StFun;
        end
      end
      StFun: begin
        if (rx_bad) begin
          state_d = StIdle;
        end else if (rx_ok) begin
          alu_en_d = 1'b1;
          fun_d    = bus.RX_P_DATA[FUN_W-1:0];
          state_d  = StAluWait;
        end
      end
      StAluWait: begin
        if (bus.ALU_OUT_VLD) begin
          tx_data_d   = bus.ALU_OUT[DATA_W-1:0];
          result_hi_d = bus.ALU_OUT[2*DATA_W-1:DATA_W];
          tx_vld_d    = 1'b1;
          state_d     = StSendLo;
        end
      end
      // A send state advances only on the cycle its byte is accepted by the FIFO.
      StSendLo: begin
        if (!bus.FIFO_FULL) begin
          tx_data_d = result_hi_q;
          state_d   = StSendHi;
        end
      end
      StSendHi, StSendRd: begin
        if (!bus.FIFO_FULL) begin
          tx_vld_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      alu_en_q    <= 1'b0;
      address_q   <= '0;
      wr_data_q   <= '0;
      fun_q       <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      result_hi_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      alu_en_q    <= alu_en_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      fun_q       <= fun_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      result_hi_q <= result_hi_d;
    end
  end

  assign bus.RF_WrEn     = wr_en_q;
  assign bus.RF_RdEn     = rd_en_q;
  assign bus.RF_Address  = address_q;
  assign bus.RF_WrData   = wr_data_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = fun_q;
  assign bus.TX_P_DATA   = tx_data_q;
  assign bus.TX_D_VLD    = tx_vld_q;
  assign bus.BUSY        = (state_q != StIdle);
  assign bus.CLK_GATE_EN = (state_q == StFun) || (state_q == StAluWait);

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Directed bench for sys_ctrl_cmd with simple register-file/ALU responders and a TX monitor.
module tb_sys_ctrl_cmd;

  typedef logic [11:0] q12_t[$];

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_mis = 0;

  sys_ctrl_cmd_if #(.DATA_W(8), .ADDR_W(4), .FUN_W(4)) bus ();

  sys_ctrl_cmd #(.DATA_W(8), .ADDR_W(4), .FUN_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Logs and protocol monitors
  q12_t wr_log, rd_log, alu_log, tx_log;
  int   stall_err   = 0;
  int   overlap_err = 0;
  logic prev_stall  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge CLK) begin
    if (RST) begin
      if (bus.RF_WrEn) wr_log.push_back({bus.RF_Address, bus.RF_WrData});
      if (bus.RF_RdEn) rd_log.push_back({8'h00, bus.RF_Address});
      if (bus.ALU_EN)  alu_log.push_back({7'h00, bus.CLK_GATE_EN, bus.ALU_FUN});
      if (bus.TX_D_VLD && !bus.FIFO_FULL) tx_log.push_back({4'h0, bus.TX_P_DATA});
      if (bus.RF_WrEn && bus.RF_RdEn) overlap_err <= overlap_err + 1;
      if (prev_stall && !(bus.TX_D_VLD && bus.TX_P_DATA == prev_data))
        stall_err <= stall_err + 1;
      prev_stall <= bus.TX_D_VLD && bus.FIFO_FULL;
      prev_data  <= bus.TX_P_DATA;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Register file returns rd_value two cycles after RF_RdEn; ALU returns alu_value three after ALU_EN
  logic [7:0]  rd_value  = 8'h9E;
  logic [15:0] alu_value = 16'h0000;
  logic [1:0]  rd_pipe   = 2'b00;
  logic [2:0]  alu_pipe  = 3'b000;

  initial begin
    bus.RF_RdData_VLD = 1'b0;
    bus.RF_RdData     = 8'h00;
    bus.ALU_OUT_VLD   = 1'b0;
    bus.ALU_OUT       = 16'h0000;
    forever begin
      @(negedge CLK);
      bus.RF_RdData_VLD = rd_pipe[1];
      bus.RF_RdData     = rd_pipe[1] ? rd_value : 8'h00;
      rd_pipe           = {rd_pipe[0], bus.RF_RdEn};
      bus.ALU_OUT_VLD   = alu_pipe[2];
      bus.ALU_OUT       = alu_pipe[2] ? alu_value : 16'h0000;
      alu_pipe          = {alu_pipe[1:0], bus.ALU_EN};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] q_at(input q12_t q, input int idx);
    return (idx < q.size()) ? q[idx] : 12'hFFF;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(negedge CLK);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    bus.RX_ERR    = err;
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b0;
    bus.RX_ERR    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!bus.BUSY) break;
    end
    check_eq(tag, {31'd0, bus.BUSY}, 32'd0);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    alu_log.delete();
    tx_log.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {bus.RF_WrEn, bus.RF_RdEn, bus.ALU_EN, bus.CLK_GATE_EN, bus.TX_D_VLD, bus.BUSY,
              bus.RF_Address, bus.RF_WrData, bus.ALU_FUN, bus.TX_P_DATA}, 32'd0);
  endtask

  initial begin
    bit seen;
    RST           = 1'b0;
    bus.RX_P_DATA = 8'h00;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_ERR    = 1'b0;
    bus.FIFO_FULL = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;

    // Unknown opcode stays idle
    clear_logs();
    send_byte(8'h55, 1'b0);
    check_eq("unknown_busy", {31'd0, bus.BUSY}, 32'd0);
    repeat (3) @(negedge CLK);
    check_eq("unknown_strobes", wr_log.size() + rd_log.size() + alu_log.size(), 0);

    // WR 5 <- 3C
    clear_logs();
    send_byte(8'hAA, 1'b0);
    check_eq("wr_busy", {31'd0, bus.BUSY}, 32'd1);
    send_byte(8'h05, 1'b0);
    send_byte(8'h3C, 1'b0);
    check_eq("wr_strobe", {bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData},
             {2'b10, 4'h5, 8'h3C});
    wait_idle("wr_idle", 10);
    check_eq("wr_count", wr_log.size(), 1);
    check_eq("wr_entry", q_at(wr_log, 0), 12'h53C);
    check_eq("wr_no_tx", tx_log.size(), 0);

    // RD 7 -> 9E
    clear_logs();
    rd_value = 8'h9E;
    send_byte(8'hBB, 1'b0);
    send_byte(8'h07, 1'b0);
    check_eq("rd_strobe", {bus.RF_RdEn, bus.RF_WrEn, bus.RF_Address}, {2'b10, 4'h7});
    wait_idle("rd_idle", 20);
    check_eq("rd_count", rd_log.size(), 1);
    check_eq("rd_tx_count", tx_log.size(), 1);
    check_eq("rd_tx_byte", q_at(tx_log, 0), 12'h09E);

    // ALU_OP 10, 20, fun 0 -> 0x0030
    clear_logs();
    alu_value = 16'h0030;
    send_byte(8'hCC, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b0);
    check_eq("aluop_strobe", {bus.ALU_EN, bus.CLK_GATE_EN, bus.ALU_FUN}, {2'b11, 4'h0});
    wait_idle("aluop_idle", 20);
    check_eq("aluop_wr_count", wr_log.size(), 2);
    check_eq("aluop_wr_a", q_at(wr_log, 0), 12'h010);
    check_eq("aluop_wr_b", q_at(wr_log, 1), 12'h120);
    check_eq("aluop_tx_count", tx_log.size(), 2);
    check_eq("aluop_tx_lo", q_at(tx_log, 0), 12'h030);
    check_eq("aluop_tx_hi", q_at(tx_log, 1), 12'h000);
    check_eq("aluop_gate_off", {31'd0, bus.CLK_GATE_EN}, 32'd0);

    // ALU_NOP fun 2 with FIFO full across SEND_LO
    clear_logs();
    alu_value     = 16'hA55A;
    bus.FIFO_FULL = 1'b1;
    send_byte(8'hDD, 1'b0);
    check_eq("nop_gate_on", {31'd0, bus.CLK_GATE_EN}, 32'd1);
    send_byte(8'h02, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.TX_D_VLD) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check_eq("bp_tx_seen", {31'd0, seen}, 32'd1);
    repeat (5) @(negedge CLK);
    check_eq("bp_hold", {bus.TX_D_VLD, bus.TX_P_DATA}, {1'b1, 8'h5A});
    check_eq("bp_no_write", tx_log.size(), 0);
    bus.FIFO_FULL = 1'b0;
    wait_idle("bp_idle", 10);
    check_eq("bp_alu_fun", q_at(alu_log, 0), 12'h012);
    check_eq("bp_tx_count", tx_log.size(), 2);
    check_eq("bp_tx_lo", q_at(tx_log, 0), 12'h05A);
    check_eq("bp_tx_hi", q_at(tx_log, 1), 12'h0A5);

    // Error byte aborts a WR, next WR still works
    clear_logs();
    send_byte(8'hAA, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h77, 1'b1);
    check_eq("err_abort", {bus.BUSY, bus.RF_WrEn}, 2'b00);
    repeat (3) @(negedge CLK);
    check_eq("err_no_wr", wr_log.size(), 0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    wait_idle("err_retry_idle", 10);
    check_eq("err_retry_wr", q_at(wr_log, 0), 12'h311);
    check_eq("err_retry_count", wr_log.size(), 1);

    // Reset mid-frame, then a fresh ALU_NOP
    clear_logs();
    send_byte(8'hCC, 1'b0);
    send_byte(8'h10, 1'b0);
    RST = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge CLK);
    RST = 1'b1;
    clear_logs();
    alu_value = 16'h1234;
    send_byte(8'hDD, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_idle("post_reset_idle", 20);
    check_eq("post_reset_wr", wr_log.size(), 0);
    check_eq("post_reset_fun", q_at(alu_log, 0), 12'h011);
    check_eq("post_reset_tx_lo", q_at(tx_log, 0), 12'h034);
    check_eq("post_reset_tx_hi", q_at(tx_log, 1), 12'h012);

    check_eq("tx_stall_stable", stall_err, 0);
    check_eq("strobe_exclusive", overlap_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_ctrl_cmd.md
Name: sys_ctrl_cmd

Overview:
- Command decoder sitting directly downstream of the UART receiver. It consumes synchronized received bytes and drives the register file and ALU.
- Read results and ALU results are returned as bytes into the TX FIFO that feeds the UART transmitter.
- Single-clock, REF_CLK-domain block. RX bytes arrive already synchronized as a one-cycle valid pulse.

Parameters:
- DATA_W, 8, UART byte / register width
- ADDR_W, 4, register file address width
- FUN_W, 4, ALU function code width

Ports:
- CLK in 1: system clock
- RST in 1: reset, asynchronous, active-low
- RX_P_DATA in DATA_W: received byte (synchronized)
- RX_D_VLD in 1: one-cycle pulse, byte valid
- RX_ERR in 1: parity or framing error on this byte; qualified by RX_D_VLD
- RF_RdData in DATA_W: register file read data
- RF_RdData_VLD in 1: read data valid pulse
- ALU_OUT in 2*DATA_W: ALU result
- ALU_OUT_VLD in 1: ALU result valid pulse
- FIFO_FULL in 1: TX FIFO full
- RF_WrEn out 1: register write strobe
- RF_RdEn out 1: register read strobe
- RF_Address out ADDR_W: register address
- RF_WrData out DATA_W: register write data
- ALU_EN out 1: ALU enable
- ALU_FUN out FUN_W: ALU function code
- CLK_GATE_EN out 1: ALU clock gate enable
- TX_P_DATA out DATA_W: byte to TX FIFO
- TX_D_VLD out 1: TX FIFO write request
- BUSY out 1: command in progress

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset mid-frame discards the partial command.
- Command bytes:
  - 0xAA WR: addr, data
  - 0xBB RD: addr
  - 0xCC ALU_OP: opA, opB, fun
  - 0xDD ALU_NOP: fun
- Unknown command byte in IDLE: ignored, FSM stays in IDLE.
- Address field: RF_Address is taken from byte[ADDR_W-1:0]. Upper bits are ignored.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, SEND_LO, SEND_HI, SEND_RD.
- WR:
  - In WR_DATA, on a valid byte: RF_WrEn=1 for exactly one cycle, with RF_Address = latched addr and RF_WrData = byte.
  - Next state: IDLE.
- RD:
  - In RD_ADDR, on a valid byte: RF_RdEn=1 for one cycle with the address, then go to RD_WAIT.
  - On RF_RdData_VLD: latch the data and go to SEND_RD.
- ALU_OP:
  - OPA writes address 0x0 and OPB writes address 0x1 (same one-cycle RF_WrEn as WR).
  - In FUN, on a valid byte: ALU_FUN = byte[FUN_W-1:0] and ALU_EN=1 for one cycle, then go to ALU_WAIT.
- ALU_NOP: goes directly to FUN. Operands already in the register file are used.
- CLK_GATE_EN: 1 from entry to FUN until exit from ALU_WAIT; 0 otherwise.
- ALU_WAIT: on ALU_OUT_VLD, latch ALU_OUT and go to SEND_LO.
- Send states:
  - Each send state drives TX_P_DATA and holds TX_D_VLD=1. A write completes on a cycle where TX_D_VLD=1 and FIFO_FULL=0.
  - While FIFO_FULL=1, TX_D_VLD and the data are held stable. No byte is lost or duplicated.
  - SEND_LO sends result[7:0] -> SEND_HI sends result[15:8] -> IDLE.
  - SEND_RD sends the read data -> IDLE.
- Error handling: RX_D_VLD with RX_ERR=1, in any state that expects a byte, drops the byte and aborts to IDLE with no RF/ALU strobe.
- Bytes arriving during RD_WAIT, ALU_WAIT or send states are ignored and do not abort.
- Strobe exclusivity: RF_WrEn and RF_RdEn are never high in the same cycle.
- BUSY: 1 in every state except IDLE.
- Latency: an RF/ALU strobe is asserted in the cycle after the RX_D_VLD that completes the field (registered outputs).

Decomposition:
- Package sys_ctrl_pkg holds:
  - command opcode constants CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - operand addresses OPA_ADDR=0, OPB_ADDR=1
  - the FSM state enum typedef
- No sub-module: the block is a single FSM with its datapath registers.

Test Plan:
- WR: send AA,05,3C -> one-cycle RF_WrEn with Address=5, WrData=0x3C. No TX_D_VLD. BUSY returns to 0.
- RD: send BB,07; model returns 0x9E two cycles after RF_RdEn -> RF_RdEn with Address=7, then one TX write of 0x9E.
- ALU_OP:
  - Send CC,10,20,00 -> writes 0x10@0 and 0x20@1, then ALU_EN with FUN=0 and CLK_GATE_EN high.
  - ALU_OUT=0x0030 -> TX bytes 0x30 then 0x00, in that order.
- FIFO backpressure: ALU_NOP DD,02 with FIFO_FULL=1 for 5 cycles during SEND_LO -> TX_D_VLD held with stable data, and each byte is written exactly once after FIFO_FULL drops.
- Error abort: send AA,03 followed by a byte with RX_ERR=1 -> no RF_WrEn and FSM back in IDLE. A following AA,03,11 writes normally.
- Reset/unknown:
  - Unknown byte 0x55 in IDLE -> ignored.
  - Assert RST low after CC,10 -> all outputs 0. After release, a fresh DD,01 executes correctly.
